// File: rtl/rata_pkg.sv
// Constants and state encoding shared by the RATA monitor and the LMT update controller.
package rata_pkg;

  localparam logic [15:0] LMT_BASE = 16'h000A;
  localparam int          LMT_SIZE = 8;
  localparam int          TS_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } lmt_state_e;

endpackage

// File: rtl/rata_lmt_update_ctrl_if.sv
// Write port between the LMT update controller and the secure memory write arbiter.
interface rata_lmt_update_ctrl_if;

  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;

  modport master (output mem_req, mem_wen, mem_addr, mem_din, input mem_gnt);
  modport slave  (input mem_req, mem_wen, mem_addr, mem_din, output mem_gnt);

endinterface

// File: rtl/rata_edge_det.sv
// Registered single-signal edge detector; FALLING selects which transition pulses.
module rata_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic puc,
  input  logic d,
  output logic pulse
);

  logic q;

  // NOTE: state in clocked blocks uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (puc) q <= 1'b0;
    else     q <= d;
  end

  assign pulse = FALLING ? (q & ~d) : (d & ~q);

endmodule

// File: rtl/rata_lmt_update_ctrl.sv
// Stamps the timestamp on each LMT update request and writes it into the LMT region word by word.
module rata_lmt_update_ctrl
  import rata_pkg::*;
#(
  parameter logic [15:0] LMT_BASE  = rata_pkg::LMT_BASE,
  parameter int          LMT_WORDS = rata_pkg::LMT_SIZE / 2,
  parameter int          TS_WIDTH  = rata_pkg::TS_WIDTH
) (
  input  logic                    clk,
  input  logic                    puc,
  input  logic                    up_lmt,
  input  logic                    rata_reset,
  input  logic [TS_WIDTH-1:0]     ts_value,
  rata_lmt_update_ctrl_if.master  mem,
  output logic                    busy,
  output logic [15:0]             lmt_seq,
  output logic                    overrun
);

  localparam int IDX_W = (LMT_WORDS > 1) ? $clog2(LMT_WORDS) : 1;

  lmt_state_e           state;
  logic [IDX_W-1:0]     idx;
  logic [TS_WIDTH-1:0]  snapshot;
  logic                 pending;
  logic                 up_rise;
  logic                 rl_fall;
  logic                 trigger;
  logic                 last_word;
  logic                 in_write;
  logic                 seq_inc;

  rata_edge_det #(.FALLING(1'b0)) u_up_edge (
    .clk   (clk),
    .puc   (puc),
    .d     (up_lmt),
    .pulse (up_rise)
  );

  rata_edge_det #(.FALLING(1'b1)) u_rl_edge (
    .clk   (clk),
    .puc   (puc),
    .d     (rata_reset),
    .pulse (rl_fall)
  );

  // The release term re-stamps after a kill while the region is still marked modified.
  assign trigger   = (up_rise & ~rata_reset) | (rl_fall & up_lmt);
  assign last_word = (idx == IDX_W'(LMT_WORDS - 1));
  assign in_write  = (state == WRITE);
  assign seq_inc   = (state == DONE) & ~rata_reset;

  always_ff @(posedge clk) begin
    if (puc) begin
      state    <= IDLE;
      idx      <= '0;
      snapshot <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else if (rata_reset) begin
      // A partial record stays in memory; the release re-stamp overwrites it.
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      if (trigger && state != IDLE) begin
        if (pending) overrun <= 1'b1;
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger || pending) begin
            snapshot <= ts_value;
            idx      <= '0;
            pending  <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (mem.mem_gnt) begin
            idx <= idx + 1'b1;
            if (last_word) state <= DONE;
          end
        end
        DONE: begin
          if (pending) begin
            snapshot <= ts_value;
            idx      <= '0;
            pending  <= 1'b0;
            state    <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Assigned every cycle so the counter always holds its own next value.
  always_ff @(posedge clk) begin
    if (puc) lmt_seq <= 16'h0000;
    else     lmt_seq <= lmt_seq + 16'(seq_inc);
  end

  assign mem.mem_req  = in_write & ~rata_reset;
  assign mem.mem_wen  = mem.mem_req & mem.mem_gnt;
  assign mem.mem_addr = in_write ? 16'(LMT_BASE + 16'({idx, 1'b0})) : 16'h0000;
  assign mem.mem_din  = in_write ? snapshot[16*idx +: 16] : 16'h0000;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_rata_lmt_update_ctrl.sv
// Directed bench for the LMT update controller: update, stall, coalesce, kill, reset and wrap.
module tb_rata_lmt_update_ctrl;

  logic        clk = 1'b0;
  logic        puc = 1'b1;
  logic        up_lmt = 1'b0;
  logic        rata_reset = 1'b0;
  logic [63:0] ts_value = 64'h0;
  logic        busy;
  logic [15:0] lmt_seq;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  rata_lmt_update_ctrl_if bus ();

  rata_lmt_update_ctrl dut (
    .clk        (clk),
    .puc        (puc),
    .up_lmt     (up_lmt),
    .rata_reset (rata_reset),
    .ts_value   (ts_value),
    .mem        (bus.master),
    .busy       (busy),
    .lmt_seq    (lmt_seq),
    .overrun    (overrun)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic wen,
                         input logic [15:0] addr, input logic [15:0] din, input logic bsy);
    #1;
    check({tag, " req"},  64'(bus.mem_req),  64'(req));
    check({tag, " wen"},  64'(bus.mem_wen),  64'(wen));
    check({tag, " addr"}, 64'(bus.mem_addr), 64'(addr));
    check({tag, " din"},  64'(bus.mem_din),  64'(din));
    check({tag, " busy"}, 64'(busy),         64'(bsy));
  endtask

  task automatic chk_word(input string tag, input int i, input logic [63:0] snap, input logic wen);
    logic [63:0] s;
    s = snap;
    chk_out($sformatf("%s w%0d", tag, i), 1'b1, wen, 16'h000A + 16'(2 * i), s[16*i +: 16], 1'b1);
  endtask

  // Four back-to-back granted words; ts_value moves on so a late snapshot would show.
  task automatic words(input string tag, input logic [63:0] snap, input logic [63:0] next_ts);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) ts_value = next_ts;
      chk_word(tag, i, snap, 1'b1);
    end
  endtask

  initial begin
    bus.mem_gnt = 1'b1;

    // Reset state
    repeat (3) step();
    chk_out("rst", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("rst seq", 64'(lmt_seq), 64'h0);
    check("rst ovr", 64'(overrun), 64'h0);
    puc = 1'b0;
    step();

    // Single update
    step(); up_lmt = 1'b1; ts_value = 64'h0011_2233_4455_6677;
    chk_out("t1 trig", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(); ts_value = 64'hDEAD_BEEF_CAFE_F00D;
    chk_out("t1 w0", 1'b1, 1'b1, 16'h000A, 16'h6677, 1'b1);
    step(); chk_out("t1 w1", 1'b1, 1'b1, 16'h000C, 16'h4455, 1'b1);
    step(); chk_out("t1 w2", 1'b1, 1'b1, 16'h000E, 16'h2233, 1'b1);
    step(); chk_out("t1 w3", 1'b1, 1'b1, 16'h0010, 16'h0011, 1'b1);
    step(); chk_out("t1 done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("t1 seq done", 64'(lmt_seq), 64'd0);
    step(); up_lmt = 1'b0;
    chk_out("t1 idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t1 seq", 64'(lmt_seq), 64'd1);

    // Grant stall for two cycles on word 1
    step(); up_lmt = 1'b1; ts_value = 64'h0011_2233_4455_6677;
    step(); ts_value = 64'h0;
    chk_out("t2 w0", 1'b1, 1'b1, 16'h000A, 16'h6677, 1'b1);
    step(); bus.mem_gnt = 1'b0;
    chk_out("t2 stall a", 1'b1, 1'b0, 16'h000C, 16'h4455, 1'b1);
    step(); chk_out("t2 stall b", 1'b1, 1'b0, 16'h000C, 16'h4455, 1'b1);
    step(); bus.mem_gnt = 1'b1;
    chk_out("t2 w1", 1'b1, 1'b1, 16'h000C, 16'h4455, 1'b1);
    step(); chk_out("t2 w2", 1'b1, 1'b1, 16'h000E, 16'h2233, 1'b1);
    step(); chk_out("t2 w3", 1'b1, 1'b1, 16'h0010, 16'h0011, 1'b1);
    step(); chk_out("t2 done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step(); up_lmt = 1'b0;
    chk_out("t2 idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t2 seq", 64'(lmt_seq), 64'd2);

    // Coalesce: two extra rising edges while writing
    step(); up_lmt = 1'b1; ts_value = 64'h1111_2222_3333_4444;
    step(); up_lmt = 1'b0; ts_value = 64'h9999_9999_9999_9999;
    chk_word("t3", 0, 64'h1111_2222_3333_4444, 1'b1);
    step(); up_lmt = 1'b1;
    chk_word("t3", 1, 64'h1111_2222_3333_4444, 1'b1);
    step(); up_lmt = 1'b0;
    chk_word("t3", 2, 64'h1111_2222_3333_4444, 1'b1);
    check("t3 ovr pre", 64'(overrun), 64'd0);
    step(); up_lmt = 1'b1;
    chk_word("t3", 3, 64'h1111_2222_3333_4444, 1'b1);
    step(); ts_value = 64'hA5A5_5A5A_0F0F_F0F0;
    chk_out("t3 done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("t3 ovr", 64'(overrun), 64'd1);
    words("t3 re", 64'hA5A5_5A5A_0F0F_F0F0, 64'h7777_7777_7777_7777);
    check("t3 seq mid", 64'(lmt_seq), 64'd3);
    step(); chk_out("t3 re done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step(); up_lmt = 1'b0;
    chk_out("t3 idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(); chk_out("t3 idle2", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t3 seq", 64'(lmt_seq), 64'd4);

    // Kill at the second word, re-stamp on release with up_lmt still high
    step(); up_lmt = 1'b1; ts_value = 64'h0123_4567_89AB_CDEF;
    step(); ts_value = 64'hFEDC_BA98_7654_3210;
    chk_word("t4", 0, 64'h0123_4567_89AB_CDEF, 1'b1);
    step(); rata_reset = 1'b1;
    chk_out("t4 kill", 1'b0, 1'b0, 16'h000C, 16'h89AB, 1'b1);
    step(); chk_out("t4 held", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t4 seq kill", 64'(lmt_seq), 64'd4);
    step(); rata_reset = 1'b0;
    chk_out("t4 release", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    words("t4 re", 64'hFEDC_BA98_7654_3210, 64'h0);
    step(); chk_out("t4 done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step(); up_lmt = 1'b0;
    chk_out("t4 idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t4 seq", 64'(lmt_seq), 64'd5);
    check("t4 ovr", 64'(overrun), 64'd1);

    // puc in the middle of an update
    step(); up_lmt = 1'b1; ts_value = 64'h5555_6666_7777_8888;
    step(); chk_word("t5", 0, 64'h5555_6666_7777_8888, 1'b1);
    step(); puc = 1'b1; up_lmt = 1'b0;
    chk_word("t5", 1, 64'h5555_6666_7777_8888, 1'b1);
    step(); puc = 1'b0;
    chk_out("t5 rst", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t5 seq", 64'(lmt_seq), 64'd0);
    check("t5 ovr", 64'(overrun), 64'd0);
    step(); up_lmt = 1'b1; ts_value = 64'hBBBB_CCCC_DDDD_EEEE;
    chk_out("t5 trig", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    words("t5 re", 64'hBBBB_CCCC_DDDD_EEEE, 64'h0);
    step(); chk_out("t5 done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step(); up_lmt = 1'b0;
    check("t5 seq after", 64'(lmt_seq), 64'd1);

    // Sequence counter wrap
    step();
    force dut.lmt_seq = 16'hFFFF;
    step();
    step();
    release dut.lmt_seq;
    #1;
    check("t6 preload", 64'(lmt_seq), 64'hFFFF);
    step(); up_lmt = 1'b1; ts_value = 64'h0000_0000_0000_0001;
    words("t6", 64'h0000_0000_0000_0001, 64'h0);
    step(); chk_out("t6 done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("t6 seq done", 64'(lmt_seq), 64'hFFFF);
    step(); up_lmt = 1'b0;
    #1;
    check("t6 wrap", 64'(lmt_seq), 64'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rata_lmt_update_ctrl.md
Name: rata_lmt_update_ctrl

Overview:
- Sequences the secure write of the Latest-Modification-Time (LMT) record whenever the RATA monitor reports an attested-region modification episode.
- On each rising edge of the monitor's upLMT, captures a snapshot of the free-running timestamp counter. It then arbitrates for the secure memory write port and writes the snapshot into the LMT region as consecutive 16-bit words.
- Sits between the RATA monitor (upLMT / reset outputs), the timer, and the LMT memory write arbiter.

Parameters:
- LMT_BASE, 16'h000A, byte address of the first LMT word.
- LMT_WORDS, 4, number of 16-bit words written per update.
- TS_WIDTH, 64, timestamp width; must equal 16*LMT_WORDS.

Ports:
- clk  in  1  system clock.
- puc  in  1  reset: synchronous, active-high.
- up_lmt  in  1  monitor upLMT level; high while AR is in the modified state.
- rata_reset  in  1  monitor kill request; aborts any update in progress.
- ts_value  in  TS_WIDTH  free-running timestamp.
- mem_req  out  1  request for the LMT write port.
- mem_gnt  in  1  port grant; may drop at any cycle.
- mem_wen  out  1  word write strobe; equals mem_req & mem_gnt in WRITE.
- mem_addr  out  16  byte address of the current word.
- mem_din  out  16  write data.
- busy  out  1  high in WRITE and DONE.
- lmt_seq  out  16  count of completed updates; wraps 16'hFFFF->0.
- overrun  out  1  sticky flag: a trigger was lost while busy.

Behaviour:
- Priority order: puc > rata_reset > all other events.
- Reset values: state IDLE, idx 0, snapshot 0, pending 0, up_lmt_q 0, rl_q 0, lmt_seq 0, overrun 0.
- Reset values of outputs: mem_req, mem_wen, mem_addr, mem_din and busy are all 0.
- up_lmt_q and rl_q register up_lmt and rata_reset every cycle, including while rata_reset is high.
- trigger = up_lmt & ~up_lmt_q & ~rata_reset, OR (rl_q & ~rata_reset & up_lmt). The second term re-stamps after a kill if the AR is still marked modified.
- IDLE:
  - On trigger: snapshot <= ts_value (sampled the same cycle), idx <= 0, go to WRITE.
  - So mem_req rises one cycle after the trigger.
- WRITE:
  - mem_req = 1.
  - mem_addr = LMT_BASE + 2*idx; mem_din = snapshot[16*idx +: 16].
  - Word order is least-significant first, ascending addresses.
  - A word is written in a cycle only if mem_gnt is high; idx then increments.
  - If mem_gnt is low, mem_wen = 0 and idx holds; mem_req stays high.
  - After word LMT_WORDS-1 is written, go to DONE.
- DONE:
  - mem_req = 0, busy = 1.
  - lmt_seq increments at the end of this cycle.
  - If pending: snapshot <= ts_value, idx <= 0, pending <= 0, go to WRITE. Otherwise go to IDLE.
- mem_addr and mem_din are 0 outside WRITE.
- Trigger in WRITE or DONE (DONE takes the trigger as pending, not as a direct restart):
  - If pending = 0, set pending <= 1.
  - If pending is already 1, set overrun <= 1. Triggers coalesce into a single follow-up update.
- rata_reset high in any state:
  - Next state IDLE, pending cleared, idx 0, mem_req and mem_wen low that same cycle (combinationally gated).
  - No lmt_seq increment; overrun unchanged.
  - A partially written record is left as-is; the re-stamp on rata_reset release overwrites it.
- puc mid-update: everything returns to reset values at the next edge.
- Full update latency with mem_gnt held high: trigger at cycle t, words written in cycles t+1..t+LMT_WORDS, DONE at t+LMT_WORDS+1, IDLE at t+LMT_WORDS+2.

Decomposition:
- Shared package rata_pkg holds:
  - LMT_BASE and LMT_SIZE constants, common with the RATA monitor.
  - A 2-bit state encoding: IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2.
  - The TS_WIDTH default.
- One natural sub-module: rata_edge_det, the registered rising/falling edge detector used for both up_lmt and rata_reset.

Test Plan:
- Single update: mem_gnt = 1, ts_value = 64'h0011_2233_4455_6677, up_lmt 0->1 at cycle 10 -> writes 16'h6677@000A, 16'h4455@000C, 16'h2233@000E, 16'h0011@0010 in cycles 11-14; lmt_seq = 1 after cycle 15; busy low at cycle 16.
- Grant stall: mem_gnt low for cycles 12-13 -> mem_wen low and idx held; the same four words still arrive in order, ending in cycle 16; lmt_seq = 1.
- Coalesce: two extra up_lmt rising edges during WRITE -> pending set, then overrun = 1; exactly one follow-up update with a fresh snapshot; lmt_seq = 2.
- Kill mid-update: rata_reset high at the second word -> mem_req low that cycle; lmt_seq unchanged. With up_lmt still high at release -> new update starts the cycle after release and rewrites all four words.
- Reset: puc asserted during WRITE -> next cycle all outputs 0, lmt_seq 0, overrun 0; up_lmt held high afterwards -> no trigger until a fresh 0->1 edge.
- Wrap: preload lmt_seq to 16'hFFFF via 65535 updates (or force) -> one more update gives lmt_seq = 16'h0000.
